mc_path_feeder: RTL and testbench

- Upstream stage of the Monte-Carlo option-pricing core.
- Generates NPATH binomial random-walk price paths over NDAY days from an LFSR and stores them in an internal array.
- Launches the pricing core, then streams one day's prices (path 0..NPATH-1, one per cycle) per pass.
- Days are served in backward-induction order (day NDAY-1 down to 0). Each `resend` pulse from the core alternately replays the current day or advances to the previous day.

---
 rtl/mc_path_feeder_if.sv | 34 +++
 rtl/mc_path_feeder.sv | 151 +++++++++++++++
 tb/tb_mc_path_feeder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mc_path_feeder_if.sv
// mc_path_feeder_if: control/stream bundle between the Monte-Carlo path feeder
// and its neighbours.
//   launch     : one-cycle request to build a new path set and run the core
//   seed       : LFSR seed, taken with an accepted launch (0 selects 16'hACE1)
//   s0, delta  : initial price and per-day step, taken with an accepted launch
//   resend     : replay/advance pulse from the pricing core
//   core_start : one-cycle start pulse to the pricing core
//   path       : price of the current stream index for the current day
//   day_idx    : day currently being streamed
//   busy       : high whenever the feeder is not idle
// master = the side that drives launch/seed/s0/delta/resend; slave = the feeder.
interface mc_path_feeder_if #(
  parameter int W = 12
);
  logic         launch;
  logic [15:0]  seed;
  logic [W-1:0] s0;
  logic [W-1:0] delta;
  logic         resend;
  logic         core_start;
  logic [W-1:0] path;
  logic [2:0]   day_idx;
  logic         busy;

  modport master (
    output launch, seed, s0, delta, resend,
    input  core_start, path, day_idx, busy
  );

  modport slave (
    input  launch, seed, s0, delta, resend,
    output core_start, path, day_idx, busy
  );
endinterface

// File: rtl/mc_path_feeder.sv
// mc_path_feeder: builds NPATH binomial random-walk price paths over NDAY days
// from a 16-bit LFSR into an internal array, pulses core_start, then streams one
// day (paths 0..NPATH-1, one per cycle) per pass, last day first. Each resend
// pulse alternately replays the current day or steps back to the previous day;
// an advance pulse on day 0 finishes the run.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : mc_path_feeder_if slave (launch/seed/s0/delta/resend in,
//           core_start/path/day_idx/busy out)
module mc_path_feeder #(
  parameter int NPATH = 256,
  parameter int NDAY  = 8,
  parameter int W     = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  mc_path_feeder_if.slave bus
);

  localparam int PW    = $clog2(NPATH);
  localparam int DW    = (NDAY > 1) ? $clog2(NDAY) : 1;
  localparam int AW    = PW + DW;
  localparam int DEPTH = NPATH * NDAY;
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_LAUNCH, S_STREAM, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_lfsr;
  logic [W-1:0]  r_s0, r_delta;
  logic [AW-1:0] r_gen_cnt;
  logic [DW-1:0] r_day;
  logic [PW-1:0] r_idx;
  logic          r_toggle;
  logic [W-1:0]  r_mem [0:DEPTH-1];

  logic          w_replay, w_advance, w_lfsr_fb;
  logic [DW-1:0] w_day_sel;
  logic [PW-1:0] w_idx_sel;
  logic [W-1:0]  w_base, w_sample;
  logic [W:0]    w_up, w_dn;

  // ---------------- path generation ----------------
  // Fibonacci taps 16,14,13,11 in right-shift form: the bit leaving at bit 0
  // is the up/down decision for the current sample.
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Day-major order means the same path's previous day sits exactly NPATH
  // entries behind the write pointer.
  assign w_base = (r_gen_cnt[AW-1:PW] == '0) ? r_s0 : r_mem[r_gen_cnt - AW'(NPATH)];
  assign w_up   = {1'b0, w_base} + {1'b0, r_delta};
  assign w_dn   = {1'b0, w_base} - {1'b0, r_delta};
  // Carry out of the sum saturates high; borrow out of the difference clamps to 0.
  assign w_sample = r_lfsr[0] ? (w_up[W] ? {W{1'b1}} : w_up[W-1:0])
                              : (w_dn[W] ? {W{1'b0}} : w_dn[W-1:0]);

  always_ff @(posedge clk) begin
    if (r_state == S_GEN) r_mem[r_gen_cnt] <= w_sample;
  end

  // ---------------- stream read ----------------
  // A resend redirects the read to element 0 in the same cycle, so the selects
  // are a mux over the registered day/index rather than the registers alone.
  assign w_replay  = (r_state == S_STREAM) && bus.resend && !r_toggle;
  assign w_advance = (r_state == S_STREAM) && bus.resend &&  r_toggle;
  assign w_day_sel = (w_advance && r_day != '0) ? r_day - DW'(1) : r_day;
  assign w_idx_sel = (w_replay || w_advance) ? '0 : r_idx;

  assign bus.path    = r_mem[{w_day_sel, w_idx_sel}];
  assign bus.day_idx = 3'(r_day);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.core_start = 1'b0;
    bus.busy       = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.launch) w_state_nxt = S_GEN;
      end
      S_GEN:    if (r_gen_cnt == AW'(DEPTH - 1)) w_state_nxt = S_LAUNCH;
      S_LAUNCH: begin
        bus.core_start = 1'b1;
        w_state_nxt    = S_STREAM;
      end
      S_STREAM: if (w_advance && r_day == '0) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr    <= LFSR_INIT;
      r_s0      <= '0;
      r_delta   <= '0;
      r_gen_cnt <= '0;
      r_day     <= '0;
      r_idx     <= '0;
      r_toggle  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.launch) begin
          r_lfsr    <= (bus.seed == 16'h0) ? LFSR_INIT : bus.seed;
          r_s0      <= bus.s0;
          r_delta   <= bus.delta;
          r_gen_cnt <= '0;
          r_day     <= '0;
          r_idx     <= '0;
          r_toggle  <= 1'b0;
        end
        S_GEN: begin
          r_lfsr    <= {w_lfsr_fb, r_lfsr[15:1]};
          r_gen_cnt <= r_gen_cnt + AW'(1);
        end
        S_LAUNCH: begin
          r_day    <= DW'(NDAY - 1);
          r_idx    <= '0;
          r_toggle <= 1'b0;
        end
        S_STREAM: begin
          if (w_advance) begin
            if (r_day != '0) begin
              r_day    <= r_day - DW'(1);
              r_idx    <= PW'(1);
              r_toggle <= 1'b0;
            end else begin
              // DONE holds the last element of day 0 on path.
              r_idx <= PW'(NPATH - 1);
            end
          end else if (w_replay) begin
            r_idx    <= PW'(1);
            r_toggle <= 1'b1;
          end else if (r_idx != PW'(NPATH - 1)) begin
            r_idx <= r_idx + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_path_feeder.sv
module tb_mc_path_feeder;
  localparam int NPATH = 8;
  localparam int NDAY  = 8;
  localparam int W     = 12;
  localparam int MAXV  = (1 << W) - 1;
  localparam int TOTAL = NPATH * NDAY;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_path_feeder_if #(.W(W)) bus();

  mc_path_feeder #(.NPATH(NPATH), .NDAY(NDAY), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int model [NDAY][NPATH];
  int obs   [NDAY][NPATH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: random walk built directly from the path rules with integers.
  task automatic build_model(input int sd, input int s, input int dl);
    int lf, base, v, fb;
    lf = sd;
    for (int d = 0; d < NDAY; d++) begin
      for (int p = 0; p < NPATH; p++) begin
        base = (d == 0) ? s : model[d-1][p];
        v = (lf & 1) ? base + dl : base - dl;
        if (v < 0) v = 0;
        if (v > MAXV) v = MAXV;
        model[d][p] = v;
        fb = (lf ^ (lf >> 2) ^ (lf >> 3) ^ (lf >> 5)) & 1;
        lf = (lf >> 1) | (fb << 15);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full launch/generate/stream run. full_len=1 gives every pass NPATH+1
  // cycles (everything observed plus one hold cycle); otherwise random lengths.
  task automatic run(input int seed_in, input int model_seed, input int s, input int dl,
                     input bit full_len);
    int lat, k, len, pn, day_e;
    bit found, done, rs;
    build_model(model_seed, s, dl);
    next_cycle();
    bus.launch = 1'b1; bus.seed = 16'(seed_in); bus.s0 = W'(s); bus.delta = W'(dl);
    @(negedge clk);
    check("busy_in_launch_cycle", bus.busy, 0);
    found = 0; lat = 0;
    for (int c = 0; c < 2000 && !found; c++) begin
      next_cycle();
      lat++;
      // Stray launches, parameter changes and resends while busy must be ignored.
      bus.launch = ($urandom_range(0, 3) == 0);
      bus.seed   = 16'($urandom);
      bus.s0     = W'($urandom);
      bus.delta  = W'($urandom);
      bus.resend = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (bus.core_start) found = 1;
    end
    check("core_start_seen", found, 1);
    if (!found) return;
    check("launch_latency", lat, TOTAL + 1);
    len = full_len ? NPATH + 1 : $urandom_range(1, NPATH + 3);
    k = 0; pn = 0; done = 0;
    for (int c = 0; c < 4000 && !done; c++) begin
      next_cycle();
      bus.launch = ($urandom_range(0, 5) == 0);
      rs = (k == len);
      bus.resend = rs;
      if (rs) begin
        pn++; k = 0;
        len = full_len ? NPATH + 1 : $urandom_range(1, NPATH + 3);
      end
      @(negedge clk);
      if (c == 0) check("core_start_single", bus.core_start, 0);
      if (pn == 2 * NDAY) begin
        done = 1;
      end else begin
        day_e = NDAY - 1 - pn / 2;
        check($sformatf("path_d%0d_k%0d", day_e, k), bus.path,
              model[day_e][(k < NPATH) ? k : NPATH - 1]);
        if (!rs) check("day_idx", bus.day_idx, day_e);
        if (k < NPATH) obs[day_e][k] = int'(bus.path);
        k++;
      end
    end
    check("stream_finished", done, 1);
    next_cycle();
    bus.resend = 1'b0; bus.launch = 1'b0;
    @(negedge clk);
    check("done_busy", bus.busy, 1);
    check("done_path", bus.path, model[0][NPATH-1]);
    next_cycle();
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_no_start", bus.core_start, 0);
    $display("run seed=%0h s0=%0d delta=%0d latency=%0d passes=%0d", seed_in, s, dl, lat, pn);
  endtask

  initial begin
    int hits, dv;
    bus.launch = 0; bus.seed = 0; bus.s0 = 0; bus.delta = 0; bus.resend = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_core_start", bus.core_start, 0);
    check("rst_day_idx", bus.day_idx, 0);
    next_cycle();
    rst_n = 1'b1;

    // Directed run: day 0 is s0 +/- delta, day 1 steps +/- delta from day 0.
    run(1, 1, 100, 10, 1);
    for (int p = 0; p < NPATH; p++) begin
      check("d0_is_90_or_110", (obs[0][p] == 90 || obs[0][p] == 110), 1);
      dv = obs[1][p] - obs[0][p];
      check("d1_step_10", (dv == 10 || dv == -10), 1);
    end

    // Saturation at both ends (first sample direction fixed by seed bit 0).
    run(2, 2, 5, 10, 1);
    check("sat_low", obs[0][0], 0);
    run(1, 1, 4090, 10, 1);
    check("sat_high", obs[0][0], MAXV);

    // Seed 0 behaves as 16'hACE1.
    run(0, 16'hACE1, int'($urandom_range(0, MAXV)), int'($urandom_range(0, 600)), 0);

    // Reset in the middle of generation aborts with no core_start afterwards.
    next_cycle();
    bus.launch = 1; bus.seed = 16'h1234; bus.s0 = 12'd2000; bus.delta = 12'd7;
    next_cycle();
    bus.launch = 0;
    repeat (30) next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    next_cycle();
    rst_n = 1'b1;
    hits = 0;
    repeat (3000) begin
      @(negedge clk);
      if (bus.core_start) hits++;
    end
    check("abort_no_core_start", hits, 0);
    $display("reset abort observed %0d core_start pulses", hits);

    // Randomized runs.
    for (int r = 0; r < 4; r++) begin
      int sd;
      sd = int'($urandom_range(1, 65535));
      run(sd, sd, int'($urandom_range(0, MAXV)), int'($urandom_range(0, 800)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
